// File: rtl/light_ctrl_pkg.sv
// Shared types and defaults for the multi-zone lighting controller.
// Imported by the per-zone FSM and the scheduler top level.
package light_ctrl_pkg;

  typedef enum logic [1:0] {
    Z_OFF  = 2'b00,
    Z_ON   = 2'b01,
    Z_HOLD = 2'b10
  } zone_state_t;

  localparam int DEFAULT_HOLD_CYCLES = 1000000;
  localparam int DEFAULT_TIMER_W     = 20;

endpackage

// File: rtl/light_zone_fsm.sv
// One lighting zone: off / on / hold state machine with a saturating hold timer.
// zone_on is registered from the state, so it trails the state by one edge.
module light_zone_fsm
  import light_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
  parameter int TIMER_W     = DEFAULT_TIMER_W
) (
  input  logic clk,
  input  logic reset,
  input  logic kill,
  input  logic active,
  output logic zone_on
);

  zone_state_t        state_r;
  zone_state_t        state_s;
  logic [TIMER_W-1:0] timer_r;
  logic [TIMER_W-1:0] timer_s;
  logic               zone_on_r;

  // State, timer and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= Z_OFF;
      timer_r   <= {TIMER_W{1'b0}};
      zone_on_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      timer_r   <= timer_s;
      zone_on_r <= (state_r != Z_OFF);
    end
  end

  // Next-state and timer logic; kill outranks everything
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    if (kill) begin
      state_s = Z_OFF;
      timer_s = {TIMER_W{1'b0}};
    end else begin
      case (state_r)
        Z_OFF: begin
          if (active) begin
            state_s = Z_ON;
          end else begin
            state_s = Z_OFF;
          end
        end
        Z_ON: begin
          if (!active) begin
            state_s = Z_HOLD;
            timer_s = TIMER_W'(HOLD_CYCLES - 1);
          end else begin
            state_s = Z_ON;
          end
        end
        Z_HOLD: begin
          if (active) begin
            state_s = Z_ON;
          end else if (timer_r == {TIMER_W{1'b0}}) begin
            state_s = Z_OFF;
          end else begin
            timer_s = timer_r - {{(TIMER_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_s = Z_OFF;
          timer_s = {TIMER_W{1'b0}};
        end
      endcase
    end
  end

  assign zone_on = zone_on_r;

endmodule

// File: rtl/light_zone_scheduler.sv
// Multi-zone lighting scheduler: per-zone FSMs feeding a single round-robin
// command port that only reports changes against the driver-acknowledged state.
module light_zone_scheduler
  import light_ctrl_pkg::*;
#(
  parameter int N_ZONES     = 4,
  parameter int ZONE_W      = 2,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
  parameter int TIMER_W     = DEFAULT_TIMER_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [N_ZONES-1:0] motion,
  input  logic [N_ZONES-1:0] override_on,
  input  logic [N_ZONES-1:0] override_off,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [ZONE_W-1:0]  cmd_zone,
  output logic               cmd_on,
  output logic [N_ZONES-1:0] zone_on,
  output logic [N_ZONES-1:0] pending
);

  logic [N_ZONES-1:0] zone_on_s;
  logic [N_ZONES-1:0] pending_s;
  logic [N_ZONES-1:0] driven_r;
  logic [ZONE_W-1:0]  rr_ptr_r;
  logic               cmd_valid_r;
  logic [ZONE_W-1:0]  cmd_zone_r;
  logic               cmd_on_r;
  logic               found_s;
  logic [ZONE_W-1:0]  sel_s;
  logic [ZONE_W-1:0]  cand_s;

  for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
    light_zone_fsm #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .TIMER_W     (TIMER_W)
    ) u_fsm (
      .clk     (clk),
      .reset   (reset),
      .kill    (override_off[z] | ~enable),
      .active  (override_on[z] | motion[z]),
      .zone_on (zone_on_s[z])
    );
  end

  assign pending_s = zone_on_s ^ driven_r;

  // Round-robin search starting just after the last granted zone
  always_comb begin
    found_s = 1'b0;
    sel_s   = {ZONE_W{1'b0}};
    cand_s  = {ZONE_W{1'b0}};
    for (int i = 1; i <= N_ZONES; i++) begin
      cand_s = ZONE_W'((int'(rr_ptr_r) + i) % N_ZONES);
      if (!found_s && pending_s[cand_s]) begin
        found_s = 1'b1;
        sel_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Command register, acknowledged-state tracking and grant pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      driven_r    <= {N_ZONES{1'b0}};
      rr_ptr_r    <= ZONE_W'(N_ZONES - 1);
      cmd_valid_r <= 1'b0;
      cmd_zone_r  <= {ZONE_W{1'b0}};
      cmd_on_r    <= 1'b0;
    end else if (cmd_valid_r) begin
      // Payload is frozen until accepted; a late change re-pends afterwards
      if (cmd_ready) begin
        driven_r[cmd_zone_r] <= cmd_on_r;
        rr_ptr_r             <= cmd_zone_r;
        cmd_valid_r          <= 1'b0;
      end
    end else if (found_s) begin
      cmd_valid_r <= 1'b1;
      cmd_zone_r  <= sel_s;
      cmd_on_r    <= zone_on_s[sel_s];
    end
  end

  assign cmd_valid = cmd_valid_r;
  assign cmd_zone  = cmd_zone_r;
  assign cmd_on    = cmd_on_r;
  assign zone_on   = zone_on_s;
  assign pending   = pending_s;

endmodule

// File: tb/tb_light_zone_scheduler.sv
// Randomised + directed bench for light_zone_scheduler with a recency-based
// zone model, a command scoreboard and per-cycle output comparison.
module tb_light_zone_scheduler;

  localparam int NZ   = 4;
  localparam int ZW   = 2;
  localparam int HOLD = 8;
  localparam int TW   = 4;
  localparam int BIG  = HOLD + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          cmd_ready = 1'b1;
  logic [NZ-1:0] motion = '0;
  logic [NZ-1:0] ov_on = '0;
  logic [NZ-1:0] ov_off = '0;
  logic          cmd_valid;
  logic [ZW-1:0] cmd_zone;
  logic          cmd_on;
  logic [NZ-1:0] zone_on;
  logic [NZ-1:0] pending;

  light_zone_scheduler #(
    .N_ZONES     (NZ),
    .ZONE_W      (ZW),
    .HOLD_CYCLES (HOLD),
    .TIMER_W     (TW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .motion       (motion),
    .override_on  (ov_on),
    .override_off (ov_off),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_zone     (cmd_zone),
    .cmd_on       (cmd_on),
    .zone_on      (zone_on),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  // Model: a zone is lit while its last qualifying activity (no kill since)
  // is at most HOLD edges old; zone_on shows that one edge later.
  int            age [NZ];
  bit [NZ-1:0]   m_zone_on;
  bit [NZ-1:0]   m_driven;
  int            m_rr;
  bit            m_valid;
  int            m_zone;
  bit            m_on;
  logic [ZW:0]   exp_q[$];
  int            tests = 0;
  int            fails = 0;
  bit            mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit [NZ-1:0] pend;
    int sel;
    if (reset) begin
      for (int z = 0; z < NZ; z++) age[z] = BIG;
      m_zone_on = '0;
      m_driven  = '0;
      m_rr      = NZ - 1;
      m_valid   = 1'b0;
      m_zone    = 0;
      m_on      = 1'b0;
      exp_q.delete();
    end else begin
      pend = m_zone_on ^ m_driven;
      if (m_valid) begin
        if (cmd_ready) begin
          m_driven[m_zone] = m_on;
          m_rr             = m_zone;
          m_valid          = 1'b0;
        end
      end else if (pend != '0) begin
        sel = -1;
        for (int i = 1; i <= NZ; i++) begin
          if (sel < 0 && pend[(m_rr + i) % NZ]) sel = (m_rr + i) % NZ;
        end
        m_valid = 1'b1;
        m_zone  = sel;
        m_on    = m_zone_on[sel];
        exp_q.push_back({ZW'(sel), m_on});
      end
      for (int z = 0; z < NZ; z++) begin
        m_zone_on[z] = (age[z] <= HOLD);
        if (ov_off[z] || !enable) age[z] = BIG;
        else if (ov_on[z] || motion[z]) age[z] = 0;
        else if (age[z] < BIG) age[z] = age[z] + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // Monitor: per-cycle comparison plus scoreboard pop on each new command
  initial begin
    logic [ZW:0] e;
    bit prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("zone_on", int'(zone_on), int'(m_zone_on));
        check("pending", int'(pending), int'(m_zone_on ^ m_driven));
        check("cmd_valid", int'(cmd_valid), int'(m_valid));
        check("cmd_zone", int'(cmd_zone), m_zone);
        check("cmd_on", int'(cmd_on), int'(m_on));
        if (cmd_valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_cmd", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("sb_zone", int'(cmd_zone), int'(e[ZW:1]));
            check("sb_on", int'(cmd_on), int'(e[0]));
          end
        end
        prev_v = cmd_valid;
      end
    end
  end

  initial begin
    int dens;
    reset = 1'b1;
    step();
    mon_en = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();

    // single motion pulse: on, hold expiry, off command
    motion = 4'b0010; step(); motion = '0;
    repeat (16) step();

    // re-trigger inside hold keeps zone 2 lit with a single ON command
    motion = 4'b0100; repeat (3) step();
    motion = '0;      repeat (5) step();
    motion = 4'b0100; repeat (2) step();
    motion = '0;      repeat (14) step();

    // simultaneous rise: commands 0, 2, 3 with idle gaps
    motion = 4'b1101; step(); motion = '0;
    repeat (16) step();

    // backpressure, then zone killed while its ON command is stalled
    cmd_ready = 1'b0;
    motion = 4'b0010; step(); motion = '0;
    repeat (5) step();
    ov_off = 4'b0010; repeat (3) step();
    cmd_ready = 1'b1; repeat (8) step();
    ov_off = '0; repeat (4) step();

    // off beats on for the same zone
    ov_on = 4'b1000; ov_off = 4'b1000; repeat (4) step();
    ov_off = '0; repeat (6) step();

    // all zones lit, then global disable drains OFF commands
    ov_on = 4'b1111; repeat (12) step();
    enable = 1'b0; repeat (12) step();
    enable = 1'b1; ov_on = '0; repeat (4) step();

    // reset in the middle of a stalled command
    cmd_ready = 1'b0;
    motion = 4'b0001; step(); motion = '0;
    repeat (4) step();
    reset = 1'b1; step(); reset = 1'b0;
    cmd_ready = 1'b1; repeat (4) step();

    // randomised traffic in blocks of varying motion density
    dens = 0;
    for (int c = 0; c < 2400; c++) begin
      if (c % 40 == 0) dens = $urandom_range(0, 4);
      for (int z = 0; z < NZ; z++) begin
        motion[z] = ($urandom_range(0, 15) < dens);
        ov_on[z]  = ($urandom_range(0, 63) == 0);
        ov_off[z] = ($urandom_range(0, 63) == 0);
      end
      enable    = ($urandom_range(0, 99) != 0);
      cmd_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 499) == 0);
      step();
    end

    motion = '0; ov_on = '0; ov_off = '0;
    enable = 1'b1; cmd_ready = 1'b1; reset = 1'b0;
    repeat (30) step();
    check("sb_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
